input_bit_shifter: RTL and testbench



---
 rtl/sys_structs_pkg.sv | 9 +
 rtl/word_hold_reg.sv | 42 ++++
 rtl/input_bit_shifter.sv | 93 +++++++++
 tb/tb_input_bit_shifter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_structs_pkg.sv
// Shared definitions for the serial shifter family (input and output bit shifters).
package sys_structs;

  // Width of a beat counter that must represent 0..depth/shift inclusive.
  function automatic int beat_cnt_width(input int depth, input int shift);
    return $clog2(depth / shift) + 1;
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry holding register with a valid/ready output handshake.
module word_hold_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             clk_en,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clk_en) begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (r_valid && i_ready) begin
        // NOTE: the data register is deliberately left alone on drain; only
        // the valid flag qualifies it, so zeroing it would cost logic for nothing.
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/input_bit_shifter.sv
// Serial-in, parallel-out deserializer: assembles LSB-first chunks into words
// and hands them to a consumer through a one-entry valid/ready holding register.
module input_bit_shifter
  import sys_structs::*;
#(
  parameter  int OUTPUT_DEPTH = 16,
  parameter  int SHIFT_DEPTH  = 1,
  localparam int BEATS        = OUTPUT_DEPTH / SHIFT_DEPTH,
  localparam int CNT_W        = beat_cnt_width(OUTPUT_DEPTH, SHIFT_DEPTH)
) (
  input  logic                    clk,
  input  logic                    async_rst_n,
  input  logic                    clk_en,
  input  logic                    shift_en_i,
  input  logic                    clear_en_i,
  input  logic [SHIFT_DEPTH-1:0]  data_i,
  input  logic                    word_ready_i,
  output logic                    word_valid_o,
  output logic [OUTPUT_DEPTH-1:0] word_data_o,
  output logic [CNT_W-1:0]        fill_count_o,
  output logic                    busy_o,
  output logic                    overflow_o
);

  if ((OUTPUT_DEPTH % SHIFT_DEPTH) != 0) begin : g_bad_depth
    $error("input_bit_shifter: OUTPUT_DEPTH must be a multiple of SHIFT_DEPTH");
  end

  logic [OUTPUT_DEPTH-1:0] r_shift_reg;
  logic [CNT_W-1:0]        r_fill_count;
  logic                    r_overflow;

  logic [OUTPUT_DEPTH-1:0] w_next_shift;
  logic                    w_shift;
  logic                    w_last_beat;
  logic                    w_complete;
  logic                    w_hold_free;
  logic                    w_load;
  logic                    w_drop;
  logic                    w_hold_valid;

  // New chunk enters at the top; the oldest chunk falls off the bottom. For
  // BEATS == 1 this reduces to data_i alone.
  assign w_next_shift = OUTPUT_DEPTH'({data_i, r_shift_reg} >> SHIFT_DEPTH);

  assign w_shift     = shift_en_i && !clear_en_i;
  assign w_last_beat = (r_fill_count == CNT_W'(BEATS - 1));
  assign w_complete  = w_shift && w_last_beat;
  // The holding slot can take a word if empty or if it drains on this edge.
  assign w_hold_free = !w_hold_valid || word_ready_i;
  assign w_load      = w_complete && w_hold_free;
  assign w_drop      = w_complete && !w_hold_free;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_shift_reg  <= '0;
      r_fill_count <= '0;
      r_overflow   <= 1'b0;
    end else if (clk_en) begin
      if (clear_en_i) begin
        r_shift_reg  <= '0;
        r_fill_count <= '0;
        r_overflow   <= 1'b0;
      end else if (w_shift) begin
        r_shift_reg  <= w_next_shift;
        r_fill_count <= w_last_beat ? '0 : r_fill_count + CNT_W'(1);
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  word_hold_reg #(
    .WIDTH (OUTPUT_DEPTH)
  ) u_hold (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .i_clear     (clear_en_i),
    .i_load      (w_load),
    .i_data      (w_next_shift),
    .i_ready     (word_ready_i),
    .o_valid     (w_hold_valid),
    .o_data      (word_data_o)
  );

  assign word_valid_o = w_hold_valid;
  assign fill_count_o = r_fill_count;
  assign busy_o       = (r_fill_count != '0);
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_input_bit_shifter.sv
// Scoreboard bench for input_bit_shifter at SHIFT_DEPTH 1, 4 and 16 (16-bit words).
module tb_input_bit_shifter;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic clr;

  always #5 clk = ~clk;

  // SHIFT_DEPTH = 1
  logic        sh1, d1, rdy1, v1, b1, ov1;
  logic [15:0] w1;
  logic [4:0]  fc1;
  // SHIFT_DEPTH = 4
  logic        sh4, rdy4, v4, b4, ov4;
  logic [3:0]  d4;
  logic [15:0] w4;
  logic [2:0]  fc4;
  // SHIFT_DEPTH = 16
  logic        sh16, rdy16, v16, b16, ov16;
  logic [15:0] d16, w16;
  logic [0:0]  fc16;

  input_bit_shifter #(.OUTPUT_DEPTH(16), .SHIFT_DEPTH(1)) dut1 (
    .clk(clk), .async_rst_n(rst_n), .clk_en(clk_en), .shift_en_i(sh1),
    .clear_en_i(clr), .data_i(d1), .word_ready_i(rdy1), .word_valid_o(v1),
    .word_data_o(w1), .fill_count_o(fc1), .busy_o(b1), .overflow_o(ov1));

  input_bit_shifter #(.OUTPUT_DEPTH(16), .SHIFT_DEPTH(4)) dut4 (
    .clk(clk), .async_rst_n(rst_n), .clk_en(clk_en), .shift_en_i(sh4),
    .clear_en_i(clr), .data_i(d4), .word_ready_i(rdy4), .word_valid_o(v4),
    .word_data_o(w4), .fill_count_o(fc4), .busy_o(b4), .overflow_o(ov4));

  input_bit_shifter #(.OUTPUT_DEPTH(16), .SHIFT_DEPTH(16)) dut16 (
    .clk(clk), .async_rst_n(rst_n), .clk_en(clk_en), .shift_en_i(sh16),
    .clear_en_i(clr), .data_i(d16), .word_ready_i(rdy16), .word_valid_o(v16),
    .word_data_o(w16), .fill_count_o(fc16), .busy_o(b16), .overflow_o(ov16));

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] q1[$];
  logic [15:0] q4[$];
  logic [15:0] q16[$];

  logic [3:0]  chunks4[4] = '{4'h3, 4'hC, 4'h5, 4'hA};
  logic [2:0]  fill4[4]   = '{3'd1, 3'd2, 3'd3, 3'd0};
  logic [15:0] b2b[3]     = '{16'h1234, 16'h5678, 16'h9ABC};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic missing(input string name, input logic [15:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got word 0x%0h expected no word", name, act);
  endtask

  // Monitors: a word is consumed on an edge where valid, ready and clk_en are all high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clk_en && v1 && rdy1) begin
      if (q1.size() == 0) missing("mon1", w1);
      else check("mon1", w1, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && clk_en && v4 && rdy4) begin
      if (q4.size() == 0) missing("mon4", w4);
      else check("mon4", w4, q4.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && clk_en && v16 && rdy16) begin
      if (q16.size() == 0) missing("mon16", w16);
      else check("mon16", w16, q16.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift bits first..first+n-1 of w into dut1, one per cycle.
  task automatic shift_bits1(input logic [15:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sh1 = 1'b1;
      d1  = w[i];
      tick();
    end
    sh1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; clr = 1'b0;
    sh1 = 1'b0; d1 = 1'b0; rdy1 = 1'b0;
    sh4 = 1'b0; d4 = '0; rdy4 = 1'b0;
    sh16 = 1'b0; d16 = '0; rdy16 = 1'b0;

    // Reset state
    tick();
    check("rst_valid", v1, 0);
    check("rst_data", w1, 0);
    check("rst_fill", fc1, 0);
    check("rst_busy", b1, 0);
    check("rst_ovf", ov1, 0);
    #2 rst_n = 1'b1;
    tick();

    // Basic 1-bit assembly with ready held high
    rdy1 = 1'b1;
    q1.push_back(16'hA5C3);
    shift_bits1(16'hA5C3, 0, 8);
    check("t1_fill_mid", fc1, 8);
    check("t1_busy_mid", b1, 1);
    shift_bits1(16'hA5C3, 8, 8);
    check("t1_valid", v1, 1);
    check("t1_data", w1, 16'hA5C3);
    check("t1_fill", fc1, 0);
    check("t1_busy", b1, 0);
    tick();
    check("t1_drained", v1, 0);

    // 4-bit chunks
    rdy4 = 1'b1;
    q4.push_back(16'hA5C3);
    for (int i = 0; i < 4; i++) begin
      sh4 = 1'b1;
      d4  = chunks4[i];
      tick();
      check("t2_fill", fc4, fill4[i]);
    end
    sh4 = 1'b0;
    check("t2_valid", v4, 1);
    check("t2_data", w4, 16'hA5C3);
    tick();

    // Backpressure and overflow
    rdy1 = 1'b0;
    q1.push_back(16'h1111);
    shift_bits1(16'h1111, 0, 16);
    check("t3_valid", v1, 1);
    check("t3_data", w1, 16'h1111);
    check("t3_ovf0", ov1, 0);
    shift_bits1(16'h2222, 0, 16);
    check("t3_ovf1", ov1, 1);
    check("t3_held", w1, 16'h1111);
    check("t3_valid_held", v1, 1);
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    check("t3_drained", v1, 0);
    check("t3_ovf_sticky", ov1, 1);
    check("t3_data_kept", w1, 16'h1111);

    // Simultaneous drain and completion
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_ovf_clr", ov1, 0);
    q1.push_back(16'h1111);
    shift_bits1(16'h1111, 0, 16);
    q1.push_back(16'h2222);
    shift_bits1(16'h2222, 0, 15);
    rdy1 = 1'b1;
    shift_bits1(16'h2222, 15, 1);
    check("t4_valid", v1, 1);
    check("t4_data", w1, 16'h2222);
    check("t4_ovf", ov1, 0);
    tick();
    check("t4_drained", v1, 0);

    // Clear beats a concurrent shift and discards held word and overflow
    rdy1 = 1'b0;
    shift_bits1(16'h3333, 0, 16);
    shift_bits1(16'h4444, 0, 16);
    shift_bits1(16'h001F, 0, 5);
    check("t5_fill5", fc1, 5);
    check("t5_ovf_set", ov1, 1);
    clr = 1'b1; sh1 = 1'b1; d1 = 1'b1;
    tick();
    clr = 1'b0; sh1 = 1'b0;
    check("t5_fill", fc1, 0);
    check("t5_busy", b1, 0);
    check("t5_valid", v1, 0);
    check("t5_ovf", ov1, 0);
    rdy1 = 1'b1;
    q1.push_back(16'hBEEF);
    shift_bits1(16'hBEEF, 0, 16);
    check("t5_data", w1, 16'hBEEF);
    tick();

    // Clock-enable freeze mid-word
    q1.push_back(16'h5A3C);
    shift_bits1(16'h5A3C, 0, 6);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sh1 = 1'b1;
      d1  = 1'b1;
      tick();
      check("t6_fill_frozen", fc1, 6);
    end
    clk_en = 1'b1;
    shift_bits1(16'h5A3C, 6, 10);
    check("t6_valid", v1, 1);
    check("t6_data", w1, 16'h5A3C);
    tick();

    // Back-to-back full-width words
    rdy16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q16.push_back(b2b[i]);
      sh16 = 1'b1;
      d16  = b2b[i];
      tick();
      check("t7_valid", v16, 1);
      check("t7_data", w16, b2b[i]);
    end
    sh16 = 1'b0;
    check("t7_fill", fc16, 0);
    tick();
    check("t7_drained", v16, 0);

    // Async reset between edges with a held word, overflow and partial word
    rdy1 = 1'b0;
    shift_bits1(16'h7777, 0, 16);
    shift_bits1(16'h8888, 0, 16);
    shift_bits1(16'hFFFF, 0, 5);
    check("t8_pre_ovf", ov1, 1);
    check("t8_pre_fill", fc1, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t8_valid", v1, 0);
    check("t8_data", w1, 0);
    check("t8_fill", fc1, 0);
    check("t8_busy", b1, 0);
    check("t8_ovf", ov1, 0);
    #2 rst_n = 1'b1;
    tick();
    check("t8_valid_after", v1, 0);

    tick();
    tick();
    check("q1_empty", q1.size(), 0);
    check("q4_empty", q4.size(), 0);
    check("q16_empty", q16.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
